// File: rtl/timer_pkg.sv
// Shared state encoding, BCD field layout and the start-time legality rule
// for the microwave countdown sequencer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Digit positions inside the 16-bit MM:SS time word.
  localparam int DIGIT_W      = 4;
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;
  localparam int TIME_W       = MIN_TENS_LSB + DIGIT_W;

  // A typed time may start cooking only if it is non-zero and its
  // seconds-tens digit is a legal clock digit.
  function automatic logic entry_valid(input logic [TIME_W-1:0] t);
    return (t != '0) && (t[SEC_TENS_LSB +: DIGIT_W] <= SEC_TENS_MAX);
  endfunction

endpackage

// File: rtl/digit_entry_reg.sv
// Keypad entry register: shifts BCD digits in from the right, with
// synchronous clear and parallel load (clear wins over load, load over shift).
module digit_entry_reg
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [TIME_W-1:0] load_data,
  input  logic              shift,
  input  logic [3:0]        digit,
  output logic [TIME_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_data;
    end else if (shift) begin
      value <= {value[MIN_ONES_LSB +: DIGIT_W],
                value[SEC_TENS_LSB +: DIGIT_W],
                value[SEC_ONES_LSB +: DIGIT_W],
                digit};
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Control FSM above the MM:SS BCD down-counter chain: keypad capture,
// quick start, cook/pause/resume gating of the 1 Hz enable and end-of-cook beep.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter logic [15:0] QUICK_START_BCD = 16'h0030,
  parameter int          BEEP_TICKS      = 3,
  parameter int          BEEP_CNT_W      = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        time_zero,
  output logic        loadn,
  output logic [15:0] load_value,
  output logic        count_en,
  output logic        magnetron_on,
  output logic        done,
  output logic        entry_error,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_ENTRY   = ENTRY;
  localparam logic [2:0] ST_COOKING = COOKING;
  localparam logic [2:0] ST_PAUSED  = PAUSED;
  localparam logic [2:0] ST_DONE    = DONE;

  localparam logic [BEEP_CNT_W-1:0] BEEP_LAST = BEEP_CNT_W'(BEEP_TICKS);

  logic [2:0]            state_next;
  logic [BEEP_CNT_W-1:0] beep_cnt, beep_next;
  logic                  load_pending, load_next;
  logic                  error_next;
  logic                  entry_clr, entry_load, entry_shift;
  logic [TIME_W-1:0]     entry;
  logic                  key_ok;

  assign key_ok = key_valid && (key_digit <= 4'd9);

  digit_entry_reg u_entry (
    .clk       (clk),
    .clr       (entry_clr),
    .load      (entry_load),
    .load_data (QUICK_START_BCD),
    .shift     (entry_shift),
    .digit     (key_digit),
    .value     (entry)
  );

  // One event wins per cycle: clear > door open > stop > start > key > tick.
  // An input only competes in states where it has an action; e.g. keys are
  // invisible while cooking, so they never swallow a tick.
  always_comb begin
    state_next  = state;
    beep_next   = beep_cnt;
    load_next   = 1'b0;
    error_next  = 1'b0;
    entry_clr   = 1'b0;
    entry_load  = 1'b0;
    entry_shift = 1'b0;
    count_en    = 1'b0;
    if (clear) begin
      entry_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && door_closed) begin
            entry_load = 1'b1;
            load_next  = 1'b1;
            state_next = ST_COOKING;
          end else if (key_ok) begin
            entry_shift = 1'b1;
            load_next   = 1'b1;
            state_next  = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (start) begin
            if (!entry_valid(entry)) begin
              error_next = 1'b1;
            end else if (door_closed) begin
              state_next = ST_COOKING;
            end
          end else if (key_ok) begin
            entry_shift = 1'b1;
            load_next   = 1'b1;
          end
        end
        ST_COOKING: begin
          if (!door_closed || stop) begin
            state_next = ST_PAUSED;
          end else begin
            count_en = tick_1hz & ~time_zero;
            // The chain may still read zero while the load is being applied.
            if (time_zero && !load_pending) state_next = ST_DONE;
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            entry_clr  = 1'b1;
            load_next  = 1'b1;
            state_next = ST_IDLE;
          end else if (start && door_closed) begin
            state_next = ST_COOKING;
          end
        end
        ST_DONE: begin
          if (stop || beep_cnt == BEEP_LAST) begin
            state_next = ST_IDLE;
          end else if (tick_1hz) begin
            beep_next = beep_cnt + BEEP_CNT_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    if (state_next != ST_DONE) beep_next = '0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= ST_IDLE;
      beep_cnt     <= '0;
      load_pending <= 1'b1;
      entry_error  <= 1'b0;
    end else begin
      state        <= state_next;
      beep_cnt     <= beep_next;
      load_pending <= load_next;
      entry_error  <= error_next;
    end
  end

  assign loadn        = ~load_pending;
  assign load_value   = entry;
  assign magnetron_on = (state == ST_COOKING);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios plus random traffic, checked
// every cycle against an event-level model with a model of the counter chain.
module tb_timer_sequencer;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
  localparam int EV_NONE = 0, EV_CLEAR = 1, EV_DOOR = 2, EV_STOP = 3,
                 EV_START = 4, EV_KEY = 5, EV_TICK = 6;
  localparam int BEEP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, tick_1hz, key_valid, start, stop, door_closed, time_zero;
  logic [3:0]  key_digit;
  logic        loadn, count_en, magnetron_on, done, entry_error;
  logic [15:0] load_value;
  logic [2:0]  state;
  logic [15:0] env_time = 16'h0000;

  assign time_zero = (env_time == 16'h0000);

  timer_sequencer #(
    .QUICK_START_BCD (16'h0030),
    .BEEP_TICKS      (3),
    .BEEP_CNT_W      (2)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .tick_1hz     (tick_1hz),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .time_zero    (time_zero),
    .loadn        (loadn),
    .load_value   (load_value),
    .count_en     (count_en),
    .magnetron_on (magnetron_on),
    .done         (done),
    .entry_error  (entry_error),
    .state        (state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = M_IDLE;
  logic [15:0] m_entry = 16'h0000;
  int          m_beep  = 0;
  bit          m_load  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_valid = 1'b0;

  function automatic int pick_event();
    bit key_ok = key_valid && (key_digit <= 4'd9);
    if (clear) return EV_CLEAR;
    if (!door_closed && m_state == M_COOK) return EV_DOOR;
    if (stop && m_state inside {M_COOK, M_PAUSE, M_DONE}) return EV_STOP;
    if (start && (m_state == M_ENTRY ||
                  (door_closed && m_state inside {M_IDLE, M_PAUSE}))) return EV_START;
    if (key_ok && m_state inside {M_IDLE, M_ENTRY}) return EV_KEY;
    if (tick_1hz && m_state inside {M_COOK, M_DONE}) return EV_TICK;
    return EV_NONE;
  endfunction

  function automatic bit exp_count_en();
    return m_valid && m_state == M_COOK && pick_event() == EV_TICK && !time_zero;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r = t;
    if (t == 16'h0000) return t;
    if (r[3:0] != 0) r[3:0] -= 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 0) r[7:4] -= 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 0) r[11:8] -= 4'd1;
        else begin
          r[11:8] = 4'd9;
          r[15:12] -= 4'd1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(output logic [15:0] env_next);
    int ev = pick_event();
    bit nl = 1'b0;
    bit ne = 1'b0;
    env_next = env_time;
    if (m_valid && m_load) env_next = m_entry;
    else if (exp_count_en()) env_next = bcd_dec(env_time);
    case (ev)
      EV_CLEAR: begin
        m_state = M_IDLE; m_entry = 16'h0000; nl = 1'b1; m_valid = 1'b1;
      end
      EV_DOOR: m_state = M_PAUSE;
      EV_STOP: begin
        if (m_state == M_PAUSE) begin
          m_entry = 16'h0000; nl = 1'b1; m_state = M_IDLE;
        end else if (m_state == M_COOK) m_state = M_PAUSE;
        else m_state = M_IDLE;
      end
      EV_START: begin
        if (m_state == M_IDLE) begin
          m_entry = 16'h0030; nl = 1'b1; m_state = M_COOK;
        end else if (m_state == M_PAUSE) m_state = M_COOK;
        else if (m_entry == 16'h0000 || m_entry[7:4] > 4'd5) ne = 1'b1;
        else if (door_closed) m_state = M_COOK;
      end
      EV_KEY: begin
        m_entry = {m_entry[11:0], key_digit}; nl = 1'b1; m_state = M_ENTRY;
      end
      default: begin
        if (m_state == M_COOK && time_zero && !m_load) m_state = M_DONE;
        else if (m_state == M_DONE) begin
          if (m_beep == BEEP) m_state = M_IDLE;
          else if (ev == EV_TICK) m_beep++;
        end
      end
    endcase
    if (m_state != M_DONE) m_beep = 0;
    m_load = nl;
    m_err  = ne;
  endtask

  // Single compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("loadn",        loadn,        !m_load);
      check("load_value",   load_value,   m_entry);
      check("count_en",     count_en,     exp_count_en());
      check("magnetron_on", magnetron_on, m_state == M_COOK);
      check("done",         done,         m_state == M_DONE);
      check("entry_error",  entry_error,  m_err);
      check("state",        state,        m_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_clock();
    logic [15:0] env_next;
    @(posedge clk);
    model_step(env_next);
    #1;
    env_time = env_next;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0;
    key_digit = 4'd0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic cycle();
    step_clock();
    idle_inputs();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    cycle();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    door_closed = 1'b1;
    idle_inputs();
    clear = 1'b1;
    step_clock();
    step_clock();
    check("reset_state", state, 0);
    check("reset_loadn", loadn, 0);
    check("reset_value", load_value, 16'h0000);
    check("reset_done",  done, 0);
    check("reset_mag",   magnetron_on, 0);
    idle_inputs();
    cycle();

    // keys 1,2,3,0 then start
    press(4'd1);
    check("key1_loadn", loadn, 0);
    check("key1_value", load_value, 16'h0001);
    press(4'd2);
    press(4'd3);
    press(4'd0);
    check("key4_value", load_value, 16'h1230);
    check("key4_state", state, 1);
    start = 1'b1;
    cycle();
    check("start_state", state, 2);
    check("start_noload", loadn, 1);
    tick_1hz = 1'b1;
    #2;
    check("tick_count_en", count_en, 1);
    cycle();
    #2;
    check("notick_count_en", count_en, 0);

    // pause then cancel, then illegal entry 0170
    stop = 1'b1; cycle();
    check("stop_paused", state, 3);
    stop = 1'b1; cycle();
    check("cancel_state", state, 0);
    check("cancel_loadn", loadn, 0);
    check("cancel_value", load_value, 16'h0000);
    press(4'd1); press(4'd7); press(4'd0);
    check("entry_0170", load_value, 16'h0170);
    start = 1'b1; cycle();
    check("illegal_error", entry_error, 1);
    check("illegal_state", state, 1);
    check("illegal_mag", magnetron_on, 0);
    cycle();
    check("error_one_clk", entry_error, 0);

    // quick start, count out, beep
    clear = 1'b1; cycle();
    start = 1'b1; cycle();
    check("quick_state", state, 2);
    check("quick_loadn", loadn, 0);
    check("quick_value", load_value, 16'h0030);
    for (int i = 0; i < 200 && m_state != M_DONE; i++) run_ticks(1);
    check("reach_done", state, 4);
    check("done_high", done, 1);
    cycle();
    run_ticks(1); check("beep1_done", done, 1);
    run_ticks(1); check("beep2_done", done, 1);
    run_ticks(1); check("beep3_done", done, 1);
    cycle();
    check("beep_idle", state, 0);
    check("beep_done_low", done, 0);

    // door pause / resume, stop beats start
    start = 1'b1; cycle();
    run_ticks(5);
    door_closed = 1'b0; cycle();
    check("door_paused", state, 3);
    check("door_mag_off", magnetron_on, 0);
    tick_1hz = 1'b1;
    #2;
    check("paused_count_en", count_en, 0);
    cycle();
    door_closed = 1'b1; start = 1'b1; cycle();
    check("resume_state", state, 2);
    check("resume_noload", loadn, 1);
    stop = 1'b1; start = 1'b1; cycle();
    check("stop_beats_start", state, 3);
    stop = 1'b1; cycle();
    check("paused_cancel", state, 0);
    check("paused_cancel_val", load_value, 16'h0000);

    // clear mid-cook together with a tick
    start = 1'b1; cycle();
    run_ticks(3);
    clear = 1'b1; tick_1hz = 1'b1;
    #2;
    check("clear_count_en", count_en, 0);
    cycle();
    check("clear_state", state, 0);
    check("clear_value", load_value, 16'h0000);
    check("clear_loadn", loadn, 0);
    check("clear_done", done, 0);
    check("clear_mag", magnetron_on, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) door_closed = ~door_closed;
      clear     = ($urandom_range(0, 299) == 0);
      tick_1hz  = ($urandom_range(0, 1) == 0);
      key_valid = ($urandom_range(0, 4) == 0);
      key_digit = 4'($urandom_range(0, 12));
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
